// File: rtl/proc_tb_pkg.sv
// -----------------------------------------------------------------------------
// proc_tb_pkg
// Shared definitions for the processor run monitor: the run FSM state
// encoding, default parameter values, the width of the small internal phase
// counters, and a saturating increment helper for those counters.
// -----------------------------------------------------------------------------
package proc_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_RESET_CYCLES   = 1;
    localparam int DEF_TIMEOUT_CYCLES = 10;
    localparam int DEF_STABLE_CYCLES  = 2;
    localparam int DEF_CNT_W          = 16;

    // Hold and stable counters only ever need to reach 255.
    localparam int PHASE_CNT_W = 8;

    function automatic logic [PHASE_CNT_W-1:0] phase_sat_inc(input logic [PHASE_CNT_W-1:0] v);
        return (v == {PHASE_CNT_W{1'b1}}) ? v : v + PHASE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   clr   - synchronous clear (wins over en)
//   en    - count enable
//   count - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/proc_run_monitor.sv
// -----------------------------------------------------------------------------
// proc_run_monitor
// Drives a processor under test through reset, lets it run, and watches its
// final result. A run passes once result has matched expected for
// STABLE_CYCLES consecutive RUN cycles, and fails if TIMEOUT_CYCLES RUN cycles
// elapse first. All outputs are registered.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-low reset
//   start       - one-cycle request to begin a run (honoured in IDLE/DONE)
//   expected    - golden result value
//   result      - processor final_result, sampled every cycle
//   core_rst    - active-high reset to the processor (low only in RUN)
//   running     - high while in RUN
//   done        - high while in DONE
//   pass        - run ended on a stable match
//   fail        - run ended on timeout
//   cycle_count - RUN cycles elapsed (saturating, frozen in DONE)
//   last_result - result captured on the final RUN cycle
// -----------------------------------------------------------------------------
module proc_run_monitor
    import proc_tb_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] result,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] last_result
);

    // ---------------------------------------------------------------- checks
    generate
        if (DATA_W < 1) begin : g_bad_data_w
            $error("proc_run_monitor: DATA_W=%0d must be at least 1", DATA_W);
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("proc_run_monitor: CNT_W=%0d outside 1..32", CNT_W);
        end
        if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
            $error("proc_run_monitor: RESET_CYCLES=%0d outside 1..255", RESET_CYCLES);
        end
        if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
            $error("proc_run_monitor: STABLE_CYCLES=%0d outside 1..255", STABLE_CYCLES);
        end
        if (TIMEOUT_CYCLES < 1 ||
            longint'(TIMEOUT_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_timeout
            $error("proc_run_monitor: TIMEOUT_CYCLES=%0d outside 1..2^CNT_W-1", TIMEOUT_CYCLES);
        end
    endgenerate

    // ------------------------------------------------------------- state
    run_state_e              state_q, state_d;
    logic [PHASE_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PHASE_CNT_W-1:0]  stable_q, stable_d;

    logic                    core_rst_q, core_rst_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;
    logic [DATA_W-1:0]       last_result_q, last_result_d;

    logic [CNT_W-1:0]        run_cnt;
    logic                    start_ok;
    logic                    match;
    logic                    pass_hit;
    logic                    timeout_hit;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign match    = (result == expected);

    // The match in the current cycle completes the streak when stable_q
    // already holds STABLE_CYCLES-1 earlier matches.
    assign pass_hit = (state_q == ST_RUN) && match &&
                      (stable_q == PHASE_CNT_W'(STABLE_CYCLES - 1));

    // Timeout yields to a same-cycle pass so the two flags stay exclusive.
    assign timeout_hit = (state_q == ST_RUN) && !pass_hit &&
                         (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // RUN-cycle counter; it also advances on the final RUN edge, so a
    // timeout leaves it equal to TIMEOUT_CYCLES, and stops once in DONE.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (start_ok),
        .en    (state_q == ST_RUN),
        .count (run_cnt)
    );

    // ------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            stable_q      <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stable_q      <= stable_d;
            core_rst_q    <= core_rst_d;
            running_q     <= running_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            last_result_q <= last_result_d;
        end
    end

    // ------------------------------------------------- next-state logic
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stable_d   = stable_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    stable_d   = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == PHASE_CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + PHASE_CNT_W'(1);
                end
            end
            ST_RUN: begin
                stable_d = match ? phase_sat_inc(stable_q) : '0;
                if (pass_hit || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- output logic
    // Outputs are computed from the next state so the registered versions
    // line up with the state they describe.
    always_comb begin
        core_rst_d    = (state_d != ST_RUN);
        running_d     = (state_d == ST_RUN);
        done_d        = (state_d == ST_DONE);
        pass_d        = pass_q;
        fail_d        = fail_q;
        last_result_d = last_result_q;
        if (start_ok) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end
        if (pass_hit) begin
            pass_d = 1'b1;
        end else if (timeout_hit) begin
            fail_d = 1'b1;
        end
        if (pass_hit || timeout_hit) begin
            last_result_d = result;
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign cycle_count = run_cnt;
    assign last_result = last_result_q;

endmodule
